serial_subtractor: RTL and testbench

Bit-serial, multi-cycle subtractor that computes D = A − B − Bin one bit per clock, LSB first. It is the inverse-direction companion of the combinational 4-bit ripple-carry adder: it trades area for latency and adds a start/done handshake for sequential datapaths. A controller issues a Start pulse with operands and collects D and Bout when Done fires.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_subtractor.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Ovf support is selected by the SERIAL_SUB_OVF_EN macro in the users of this package.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned SUB_WIDTH = 4;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = serial_sub_pkg::SUB_WIDTH
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             Ovf;

    modport master (
        output Start, A, B, Bin,
        input  Busy, Done, D, Bout, Ovf
    );

    modport slave (
        input  Start, A, B, Bin,
        output Busy, Done, D, Bout, Ovf
    );
`else
    modport master (
        output Start, A, B, Bin,
        input  Busy, Done, D, Bout
    );

    modport slave (
        input  Start, A, B, Bin,
        output Busy, Done, D, Bout
    );
`endif
endinterface

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH
) (
    input  logic                Clk,
    input  logic                Rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned           CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               fs_diff_c;
    logic               fs_bout_c;
`ifdef SERIAL_SUB_OVF_EN
    logic               br_msb_q, br_msb_d;
    logic               ovf_q, ovf_d;
`endif

    full_subtractor u_full_subtractor (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_diff_c),
        .bout (fs_bout_c)
    );

    // Next-state and datapath: capture in IDLE, one bit per SHIFT cycle, publish in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        bout_d   = bout_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        br_msb_d = br_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout_c;
                res_d = {fs_diff_c, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow entering the MSB, needed for signed overflow.
                    br_msb_d = br_q;
`endif
                    state_d = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                d_d     = res_q;
                bout_d  = br_q;
                done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d   = br_msb_q ^ br_q;
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            br_msb_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
            br_msb_q <= br_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.Done = done_q;
    assign bus.Busy = busy_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor; honours SERIAL_SUB_OVF_EN if defined.
module tb_serial_subtractor;

    localparam int unsigned W      = 4;
    localparam int unsigned PERIOD = 10;

    logic Clk;
    logic Rst_n;
    logic ovf_obs;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

`ifdef SERIAL_SUB_OVF_EN
    assign ovf_obs = bus.Ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    initial Clk = 1'b0;
    always #(PERIOD / 2) Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] got_q[$];
    time          done_t_q[$];

    // Collect every completion as {D, Bout, Ovf}.
    always @(negedge Clk) begin
        if (bus.Done === 1'b1) begin
            got_q.push_back({bus.D, bus.Bout, ovf_obs});
            done_t_q.push_back($time);
            done_cnt = done_cnt + 1;
        end
    end

    // Reference: {D, Bout, Ovf} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int   diff;
        int   sdiff;
        int   lim;
        logic ovf;
        diff  = int'(a) - int'(b) - int'(bin);
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
        lim   = 1 << (W - 1);
        ovf   = (sdiff < -lim) || (sdiff >= lim);
`ifndef SERIAL_SUB_OVF_EN
        ovf   = 1'b0;
`endif
        return {W'(diff), (diff < 0), ovf};
    endfunction

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input bit push);
        @(posedge Clk);
        #1;
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        if (push) exp_q.push_back(model(a, b, bin));
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_result(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        #1;
        n_cmp++; if (bus.D !== '0)       begin n_bad++; $display("FAIL reset_d: got %b exp 0", bus.D); end
        n_cmp++; if (bus.Bout !== 1'b0)  begin n_bad++; $display("FAIL reset_bout: got %b exp 0", bus.Bout); end
        n_cmp++; if (bus.Busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b exp 0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b exp 0", bus.Done); end
        n_cmp++; if (ovf_obs !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b exp 0", ovf_obs); end
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int busy_cycles = 0;
        int done_cycles = 0;
        int done_at     = -1;
        bit ok;
        logic [W+1:0] e, g;
        exp_q.delete(); got_q.delete();
        drive_op(4'b0011, 4'b0001, 1'b0, 1'b1);
        for (int c = 0; c < int'(W) + 4; c++) begin
            @(negedge Clk);
            if (bus.Busy === 1'b1) busy_cycles++;
            if (bus.Done === 1'b1) begin done_cycles++; done_at = c; end
        end
        n_cmp++; if (busy_cycles != int'(W)) begin n_bad++; $display("FAIL basic_busy_len: got %0d exp %0d", busy_cycles, W); end
        n_cmp++; if (done_cycles != 1)       begin n_bad++; $display("FAIL basic_done_len: got %0d exp 1", done_cycles); end
        n_cmp++; if (done_at != int'(W) + 1) begin n_bad++; $display("FAIL basic_latency: got %0d exp %0d", done_at, W + 1); end
        wait_result(4, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL basic_timeout: got no Done exp one result");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL basic_result: got %b exp %b", g, e); end
        end
        // Result stays on D/Bout after Done drops.
        n_cmp++; if (bus.D !== 4'b0010 || bus.Bout !== 1'b0)
            begin n_bad++; $display("FAIL basic_hold: got %b/%b exp 0010/0", bus.D, bus.Bout); end
    endtask

    task automatic test_vectors(input string name, input logic [W-1:0] va[], input logic [W-1:0] vb[],
                                input logic vbin[]);
        bit ok;
        logic [W+1:0] e, g;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < va.size(); i++) begin
            drive_op(va[i], vb[i], vbin[i], 1'b1);
            wait_result(int'(W) + 6, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL %s_timeout[%0d]: got no Done exp one result", name, i);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                n_cmp++; if (g !== e) begin n_bad++; $display("FAIL %s[%0d]: got %b exp %b", name, i, g, e); end
            end
        end
    endtask

    task automatic test_borrow();
        test_vectors("borrow", '{4'b0000, 4'b0000}, '{4'b0001, 4'b0000}, '{1'b0, 1'b1});
    endtask

    task automatic test_overflow();
        test_vectors("overflow", '{4'b0111, 4'b0111}, '{4'b1111, 4'b1111}, '{1'b0, 1'b1});
    endtask

    task automatic test_random();
        logic [W-1:0] ra[];
        logic [W-1:0] rb[];
        logic         rbin[];
        ra = new[8]; rb = new[8]; rbin = new[8];
        for (int i = 0; i < 8; i++) begin
            ra[i]   = W'($urandom_range(0, (1 << W) - 1));
            rb[i]   = W'($urandom_range(0, (1 << W) - 1));
            rbin[i] = 1'($urandom_range(0, 1));
        end
        test_vectors("random", ra, rb, rbin);
    endtask

    task automatic test_start_ignored();
        int done_before;
        bit ok;
        logic [W+1:0] e, g;
        exp_q.delete(); got_q.delete();
        done_before = done_cnt;
        drive_op(4'b0110, 4'b0010, 1'b0, 1'b1);
        // Re-request with different operands while shifting.
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.A = 4'b1111; bus.B = 4'b0000; bus.Bin = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        wait_result(int'(W) + 6, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL ignored_timeout: got no Done exp one result");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ignored_result: got %b exp %b", g, e); end
        end
        repeat (3 * (W + 2)) @(negedge Clk);
        n_cmp++; if (done_cnt - done_before != 1)
            begin n_bad++; $display("FAIL ignored_extra_done: got %0d exp 1", done_cnt - done_before); end
    endtask

    task automatic test_async_reset();
        int done_before;
        bit ok;
        logic [W+1:0] e, g;
        exp_q.delete(); got_q.delete();
        drive_op(4'b1001, 4'b0011, 1'b0, 1'b0);
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.D !== '0)      begin n_bad++; $display("FAIL arst_d: got %b exp 0", bus.D); end
        n_cmp++; if (bus.Bout !== 1'b0) begin n_bad++; $display("FAIL arst_bout: got %b exp 0", bus.Bout); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b exp 0", bus.Busy); end
        n_cmp++; if (ovf_obs !== 1'b0)  begin n_bad++; $display("FAIL arst_ovf: got %b exp 0", ovf_obs); end
        done_before = done_cnt;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3 * (W + 2)) @(negedge Clk);
        n_cmp++; if (done_cnt != done_before)
            begin n_bad++; $display("FAIL arst_spurious_done: got %0d exp 0", done_cnt - done_before); end
        got_q.delete();
        drive_op(4'b1100, 4'b0101, 1'b1, 1'b1);
        wait_result(int'(W) + 6, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL arst_recover_timeout: got no Done exp one result");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL arst_recover: got %b exp %b", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        int  done_before;
        bit  ok = 1'b0;
        time t0, t1;
        logic [W+1:0] e, g;
        exp_q.delete(); got_q.delete(); done_t_q.delete();
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.A = 4'b1010; bus.B = 4'b0101; bus.Bin = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(4'b1010, 4'b0101, 1'b1));
        for (int i = 0; i < 6 * int'(W + 2); i++) begin
            @(negedge Clk); #1;
            if (got_q.size() >= 3) begin ok = 1'b1; break; end
        end
        // Dropped during the Done cycle, so no further capture.
        bus.Start = 1'b0;
        done_before = done_cnt;
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL b2b_timeout: got %0d results exp 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_result[%0d]: got %b exp %b", i, g, e); end
            end
            for (int i = 0; i < 2; i++) begin
                t0 = done_t_q[i]; t1 = done_t_q[i + 1];
                n_cmp++; if (t1 - t0 != (W + 2) * PERIOD)
                    begin n_bad++; $display("FAIL b2b_period[%0d]: got %0t exp %0d", i, t1 - t0, (W + 2) * PERIOD); end
            end
        end
        repeat (2 * (W + 2)) @(negedge Clk);
        n_cmp++; if (done_cnt != done_before)
            begin n_bad++; $display("FAIL b2b_tail_done: got %0d exp 0", done_cnt - done_before); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
